// File: rtl/dclk_tx.sv
`default_nettype none
// ============================================================================
//  Module   : dclk_tx
//  Purpose  : Serial flit transmitter feeding dclk_rx over a single wire.
//  Revision : 1.0
// ============================================================================

`ifndef HDR_SZ
`define HDR_SZ 4
`endif
`ifndef PL_SZ
`define PL_SZ 8
`endif
`ifndef ADDR_SZ
`define ADDR_SZ 4
`endif

module dclk_tx #(
  parameter int    FLIT_W  = `HDR_SZ + `PL_SZ + `ADDR_SZ,
  parameter int    GAP_CYC = 2,
  parameter string PORT    = "unknown"
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic [FLIT_W-1:0] parallel_in,
  output logic              ready,
  input  logic              channel_busy,
  output logic              serial_out,
  output logic              tx_busy
);

  localparam int c_cnt_w = $clog2(FLIT_W + 1);
  localparam int c_gap_w = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(FLIT_W - 1);
  localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_SHIFT = 3'd2,
    S_GAP   = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t              r_state;
  logic [FLIT_W-1:0]   r_shreg;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [c_gap_w-1:0]  r_gcnt;
  logic                r_seen_busy;
  logic                r_sync_meta;
  logic                r_busy_s;
  logic                r_serial;

  state_t              w_state_nxt;
  logic [FLIT_W-1:0]   w_shreg_nxt;
  logic [c_cnt_w-1:0]  w_cnt_nxt;
  logic [c_gap_w-1:0]  w_gcnt_nxt;
  logic                w_seen_nxt;
  logic                w_serial_nxt;
  logic                w_accept;
  logic                w_release;

  // ready is forced low while reset is held, even though state reads IDLE then
  assign ready      = reset && (r_state == S_IDLE) && !r_busy_s;
  assign w_accept   = ready && req;
  assign w_release  = r_seen_busy && !r_busy_s;
  assign serial_out = r_serial;
  assign tx_busy    = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync_meta <= 1'b0;
      r_busy_s    <= 1'b0;
    end else begin
      r_sync_meta <= channel_busy;
      r_busy_s    <= r_sync_meta;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_shreg     <= '0;
      r_cnt       <= '0;
      r_gcnt      <= '0;
      r_seen_busy <= 1'b0;
      r_serial    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shreg     <= w_shreg_nxt;
      r_cnt       <= w_cnt_nxt;
      r_gcnt      <= w_gcnt_nxt;
      r_seen_busy <= w_seen_nxt;
      r_serial    <= w_serial_nxt;
    end
  end

  // serial_out is registered, so each branch computes what the line shows next cycle
  always_comb begin
    w_state_nxt  = r_state;
    w_shreg_nxt  = r_shreg;
    w_cnt_nxt    = r_cnt;
    w_gcnt_nxt   = r_gcnt;
    w_seen_nxt   = r_seen_busy;
    w_serial_nxt = 1'b0;

    if ((r_state != S_IDLE) && r_busy_s) begin
      w_seen_nxt = 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt  = S_START;
          w_shreg_nxt  = parallel_in;
          w_cnt_nxt    = '0;
          w_gcnt_nxt   = '0;
          w_seen_nxt   = 1'b0;
          w_serial_nxt = 1'b1;
        end
      end
      S_START: begin
        w_state_nxt  = S_SHIFT;
        w_serial_nxt = r_shreg[0];
        w_shreg_nxt  = r_shreg >> 1;
      end
      S_SHIFT: begin
        if (r_cnt == c_cnt_last) begin
          w_gcnt_nxt = '0;
          if (GAP_CYC > 0) begin
            w_state_nxt = S_GAP;
          end else begin
            w_state_nxt = w_release ? S_IDLE : S_DRAIN;
          end
        end else begin
          w_cnt_nxt    = r_cnt + 1'b1;
          w_serial_nxt = r_shreg[0];
          w_shreg_nxt  = r_shreg >> 1;
        end
      end
      S_GAP: begin
        // A receiver that has already freed lets the last gap cycle go straight to IDLE
        if (r_gcnt == c_gap_last) begin
          w_state_nxt = w_release ? S_IDLE : S_DRAIN;
        end else begin
          w_gcnt_nxt = r_gcnt + 1'b1;
        end
      end
      S_DRAIN: begin
        if (w_release) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_dclk_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dclk_tx
//  Purpose  : Directed scoreboard bench for dclk_tx (FLIT_W=16, GAP_CYC=2).
//  Revision : 1.0
// ============================================================================
module tb_dclk_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic [15:0] parallel_in;
  logic        ready;
  logic        channel_busy;
  logic        serial_out;
  logic        tx_busy;

  int n_checks = 0;
  int n_errors = 0;
  logic exp_q[$];

  dclk_tx #(.FLIT_W(16), .GAP_CYC(2), .PORT("tb")) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .parallel_in  (parallel_in),
    .ready        (ready),
    .channel_busy (channel_busy),
    .serial_out   (serial_out),
    .tx_busy      (tx_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line: start bit then data LSB first; an empty queue means the line is low.
  task automatic push_frame(input logic [15:0] d);
    exp_q.push_back(1'b1);
    for (int i = 0; i < 16; i++) exp_q.push_back(d[i]);
  endtask

  task automatic cyc();
    logic e;
    @(negedge clk);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b0;
    check("serial_out", {31'd0, serial_out}, {31'd0, e});
  endtask

  // Called at the negedge before the expected accept edge; returns in the last gap cycle.
  task automatic frame(input logic [15:0] d, input bit rx_reads, input bit keep_req,
                       input logic [15:0] d_next);
    check("ready_pre_accept", {31'd0, ready}, 32'd1);
    req = 1'b1;
    parallel_in = d;
    push_frame(d);
    cyc();
    check("tx_busy_start", {31'd0, tx_busy}, 32'd1);
    check("ready_start", {31'd0, ready}, 32'd0);
    if (keep_req) parallel_in = d_next;
    else req = 1'b0;
    if (rx_reads) channel_busy = 1'b1;
    repeat (16) cyc();
    if (rx_reads) channel_busy = 1'b0;
    repeat (2) cyc();
  endtask

  initial begin
    reset = 1'b0;
    req = 1'b0;
    parallel_in = '0;
    channel_busy = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_serial", {31'd0, serial_out}, 32'd0);
    check("rst_tx_busy", {31'd0, tx_busy}, 32'd0);
    check("rst_ready", {31'd0, ready}, 32'd0);
    reset = 1'b1;
    cyc();
    check("ready_after_reset", {31'd0, ready}, 32'd1);

    // Receiver busy before any accept: request is held off until the sync catches up
    channel_busy = 1'b1;
    repeat (3) cyc();
    check("ready_busy_hold", {31'd0, ready}, 32'd0);
    req = 1'b1;
    parallel_in = 16'hA5C3;
    repeat (3) begin
      cyc();
      check("ready_while_busy", {31'd0, ready}, 32'd0);
      check("tx_busy_while_busy", {31'd0, tx_busy}, 32'd0);
    end
    channel_busy = 1'b0;
    cyc();
    check("ready_sync_delay", {31'd0, ready}, 32'd0);
    cyc();

    // A5C3 frame, receiver never raises busy yet: DRAIN must hold
    frame(16'hA5C3, 1'b0, 1'b0, 16'h0000);
    repeat (5) cyc();
    check("drain_ready", {31'd0, ready}, 32'd0);
    check("drain_tx_busy", {31'd0, tx_busy}, 32'd1);
    channel_busy = 1'b1;
    repeat (3) cyc();
    channel_busy = 1'b0;
    cyc();
    check("drain_rel1_ready", {31'd0, ready}, 32'd0);
    cyc();
    check("drain_rel2_ready", {31'd0, ready}, 32'd0);
    check("drain_rel2_tx_busy", {31'd0, tx_busy}, 32'd1);
    cyc();
    check("drain_rel3_ready", {31'd0, ready}, 32'd1);
    check("drain_rel3_tx_busy", {31'd0, tx_busy}, 32'd0);
    repeat (2) cyc();
    check("idle_no_req_tx_busy", {31'd0, tx_busy}, 32'd0);

    // All-zero flit with req held for the next flit; no second accept while DRAIN holds
    frame(16'h0000, 1'b0, 1'b1, 16'hFFFF);
    repeat (30) cyc();
    check("held_req_ready", {31'd0, ready}, 32'd0);
    check("held_req_tx_busy", {31'd0, tx_busy}, 32'd1);
    channel_busy = 1'b1;
    repeat (3) cyc();
    channel_busy = 1'b0;
    repeat (3) cyc();

    // Held FFFF is accepted now; reset it mid-shift
    check("ready_ffff", {31'd0, ready}, 32'd1);
    push_frame(16'hFFFF);
    cyc();
    req = 1'b0;
    repeat (6) cyc();
    reset = 1'b0;
    #1;
    check("midrst_serial", {31'd0, serial_out}, 32'd0);
    check("midrst_tx_busy", {31'd0, tx_busy}, 32'd0);
    check("midrst_ready", {31'd0, ready}, 32'd0);
    exp_q.delete();
    repeat (2) cyc();
    check("midrst_hold_ready", {31'd0, ready}, 32'd0);
    reset = 1'b1;
    cyc();
    check("post_rst_ready", {31'd0, ready}, 32'd1);
    check("post_rst_tx_busy", {31'd0, tx_busy}, 32'd0);

    // Back-to-back with a prompt receiver: accept spacing of exactly 20 cycles
    frame(16'h1357, 1'b1, 1'b1, 16'h8ACE);
    check("b2b_ready_early", {31'd0, ready}, 32'd0);
    cyc();
    frame(16'h8ACE, 1'b1, 1'b0, 16'h0000);
    cyc();
    check("b2b_end_ready", {31'd0, ready}, 32'd1);
    check("b2b_end_tx_busy", {31'd0, tx_busy}, 32'd0);
    repeat (3) cyc();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
